// File: rtl/jt12_acc_seq.sv
// Slot scheduler for the FM output accumulator: walks 4*NCH operator slots per sample and
// serves per-channel rl/alg from a double-buffered register file committed at frame end.
module jt12_acc_seq #(
    parameter int unsigned NCH    = 6,
    parameter logic [1:0]  RL_RST = 2'b11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       cfg_we,
    input  logic [2:0] cfg_ch,
    input  logic [1:0] cfg_rl,
    input  logic [2:0] cfg_alg,
    input  logic       cfg_pcm_we,
    input  logic       cfg_pcm,
    output logic       zero,
    output logic       s1_enters,
    output logic       s2_enters,
    output logic       s3_enters,
    output logic       s4_enters,
    output logic       ch6op,
    output logic [2:0] cur_ch,
    output logic [2:0] alg,
    output logic [1:0] rl,
    output logic       pcm_en
);

    localparam logic [2:0] LastCh  = 3'(NCH - 1);
    localparam logic [4:0] CfgRst  = {RL_RST, 3'd0};

    logic [2:0] ch_q;
    logic [1:0] grp_q;
    logic [4:0] stg_q [NCH];
    logic [4:0] stg_d [NCH];
    logic [4:0] act_q [NCH];
    logic       stg_pcm_q, stg_pcm_d;
    logic       act_pcm_q;
    logic [4:0] act_sel;
    logic       last_slot;

    assign last_slot = (grp_q == 2'd3) && (ch_q == LastCh);

    // Staging writes are visible combinationally so a commit on the same edge picks them up.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            stg_d[i] = stg_q[i];
            if (cfg_we && cfg_ch == 3'(i)) begin
                stg_d[i] = {cfg_rl, cfg_alg};
            end
        end
        stg_pcm_d = cfg_pcm_we ? cfg_pcm : stg_pcm_q;
    end

    always_comb begin
        act_sel = CfgRst;
        for (int i = 0; i < NCH; i++) begin
            if (ch_q == 3'(i)) begin
                act_sel = act_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                stg_q[i] <= CfgRst;
                act_q[i] <= CfgRst;
            end
            stg_pcm_q <= 1'b0;
            act_pcm_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                stg_q[i] <= stg_d[i];
                if (clk_en && last_slot) begin
                    act_q[i] <= stg_d[i];
                end
            end
            stg_pcm_q <= stg_pcm_d;
            if (clk_en && last_slot) begin
                act_pcm_q <= stg_pcm_d;
            end
        end
    end

    // Outputs decode the pre-advance counter, i.e. the slot consumed on this same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q      <= 3'd0;
            grp_q     <= 2'd0;
            zero      <= 1'b0;
            s1_enters <= 1'b0;
            s2_enters <= 1'b0;
            s3_enters <= 1'b0;
            s4_enters <= 1'b0;
            ch6op     <= 1'b0;
            cur_ch    <= 3'd0;
            alg       <= 3'd0;
            rl        <= RL_RST;
            pcm_en    <= 1'b0;
        end else if (clk_en) begin
            if (ch_q == LastCh) begin
                ch_q  <= 3'd0;
                grp_q <= grp_q + 2'd1;
            end else begin
                ch_q  <= ch_q + 3'd1;
            end
            zero      <= (grp_q == 2'd0) && (ch_q == 3'd0);
            s1_enters <= (grp_q == 2'd0);
            s3_enters <= (grp_q == 2'd1);
            s2_enters <= (grp_q == 2'd2);
            s4_enters <= (grp_q == 2'd3);
            ch6op     <= (ch_q == LastCh);
            cur_ch    <= ch_q;
            alg       <= act_sel[2:0];
            rl        <= act_sel[4:3];
            pcm_en    <= act_pcm_q;
        end
    end

endmodule
